// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM receive path.
//   - tdm_state_e   : lock-machine state encoding (HUNT, LOCKING, LOCKED)
//   - cnt_width()   : width of the slot counter for a given channel count
// -----------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        LOCKING = 2'b01,
        LOCKED  = 2'b10
    } tdm_state_e;

    // A single-channel frame still needs a 1-bit counter so the
    // counter logic stays uniform.
    function automatic int cnt_width(input int channels);
        if (channels <= 1) begin
            return 1;
        end
        return $clog2(channels);
    endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_counter.sv
// -----------------------------------------------------------------------------
// tdm_slot_counter
// Wrap-around slot position counter for the TDM demultiplexer.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   advance     : step to the next slot, wrapping CHANNELS-1 -> 0
//   load_one    : treat the current slot as slot 0, so the next is slot 1
//                 (stays at 0 when CHANNELS = 1)
//   clear       : return to slot 0
//   cnt         : current slot position
//   is_first    : cnt == 0
//   is_last     : cnt == CHANNELS-1
// Priority when several controls are high: clear > load_one > advance.
// -----------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CW       = cnt_width(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          load_one,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output logic          is_first,
    output logic          is_last
);

    localparam logic [CW-1:0] LAST_VAL = CW'(CHANNELS - 1);
    localparam logic [CW-1:0] LOAD_VAL = (CHANNELS > 1) ? CW'(1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load_one) begin
            cnt_d = LOAD_VAL;
        end else if (advance) begin
            cnt_d = (cnt_q == LAST_VAL) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign is_first = (cnt_q == '0);
    assign is_last  = (cnt_q == LAST_VAL);

endmodule : tdm_slot_counter

// File: rtl/tdm_demultiplexer.sv
// -----------------------------------------------------------------------------
// tdm_demultiplexer
// Receive side of a TDM slot stream. Acquires frame alignment from FrameSync
// with a HUNT / LOCKING / LOCKED machine and, once locked, copies each slot
// word into that channel's holding register with a one-cycle strobe.
// Ports:
//   Clock, Reset_n : clock, asynchronous active-low reset
//   Enable         : gates slot acceptance; low freezes all state
//   SlotIn         : slot data word
//   SlotValid      : SlotIn / FrameSync valid this cycle
//   FrameSync      : marks slot 0 (qualified by SlotValid)
//   ChanOut        : holding registers, channel k at [k*WIDTH +: WIDTH]
//   ChanStrobe     : bit k pulses when channel k is written
//   FrameDone      : pulses with the write of channel CHANNELS-1
//   Locked         : high while in LOCKED
//   SyncError      : pulses on an alignment error
// All outputs are registered; one cycle of latency from accepted slot.
// -----------------------------------------------------------------------------
module tdm_demultiplexer
    import tdm_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      Enable,
    input  logic [WIDTH-1:0]          SlotIn,
    input  logic                      SlotValid,
    input  logic                      FrameSync,
    output logic [CHANNELS*WIDTH-1:0] ChanOut,
    output logic [CHANNELS-1:0]       ChanStrobe,
    output logic                      FrameDone,
    output logic                      Locked,
    output logic                      SyncError
);

    localparam int CW = cnt_width(CHANNELS);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_FRAMES);

    tdm_state_e                state_q,       state_d;
    logic [GW-1:0]             good_q,        good_d;
    logic [CHANNELS*WIDTH-1:0] chan_out_q,    chan_out_d;
    logic [CHANNELS-1:0]       chan_strobe_q, chan_strobe_d;
    logic                      frame_done_q,  frame_done_d;
    logic                      locked_q,      locked_d;
    logic                      sync_error_q,  sync_error_d;

    logic          accept;
    logic          align_err;
    logic          cnt_advance;
    logic          cnt_load_one;
    logic          cnt_clear;
    logic [CW-1:0] cnt;
    logic          cnt_is_first;
    logic          cnt_is_last;

    tdm_slot_counter #(
        .CHANNELS (CHANNELS),
        .CW       (CW)
    ) u_slot_counter (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .advance  (cnt_advance),
        .load_one (cnt_load_one),
        .clear    (cnt_clear),
        .cnt      (cnt),
        .is_first (cnt_is_first),
        .is_last  (cnt_is_last)
    );

    assign accept = Enable & SlotValid;

    // Sync must coincide exactly with slot 0: early sync or missing sync.
    assign align_err = (FrameSync & ~cnt_is_first) | (~FrameSync & cnt_is_first);

    always_comb begin
        state_d       = state_q;
        good_d        = good_q;
        chan_out_d    = chan_out_q;
        chan_strobe_d = '0;
        frame_done_d  = 1'b0;
        sync_error_d  = 1'b0;
        cnt_advance   = 1'b0;
        cnt_load_one  = 1'b0;
        cnt_clear     = 1'b0;

        case (state_q)
            HUNT: begin
                // Only a sync word can start acquisition; everything else is
                // silently discarded while hunting.
                if (accept && FrameSync) begin
                    state_d      = LOCKING;
                    good_d       = '0;
                    cnt_load_one = 1'b1;
                end
            end

            LOCKING, LOCKED: begin
                if (accept) begin
                    if (align_err) begin
                        sync_error_d = 1'b1;
                        good_d       = '0;
                        if (FrameSync) begin
                            // Early sync: re-align on this slot as slot 0.
                            state_d      = LOCKING;
                            cnt_load_one = 1'b1;
                        end else begin
                            state_d   = HUNT;
                            cnt_clear = 1'b1;
                        end
                    end else begin
                        cnt_advance = 1'b1;
                        if (state_q == LOCKED) begin
                            for (int k = 0; k < CHANNELS; k++) begin
                                if (cnt == CW'(k)) begin
                                    chan_out_d[k*WIDTH +: WIDTH] = SlotIn;
                                    chan_strobe_d[k]             = 1'b1;
                                end
                            end
                            frame_done_d = cnt_is_last;
                        end else if (cnt_is_last) begin
                            if (good_q < GOOD_MAX) begin
                                good_d = good_q + GW'(1);
                            end
                            if (good_d == GOOD_MAX) begin
                                state_d = LOCKED;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d   = HUNT;
                good_d    = '0;
                cnt_clear = 1'b1;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= HUNT;
            good_q        <= '0;
            chan_out_q    <= '0;
            chan_strobe_q <= '0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            chan_out_q    <= chan_out_d;
            chan_strobe_q <= chan_strobe_d;
            frame_done_q  <= frame_done_d;
            locked_q      <= locked_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign ChanOut    = chan_out_q;
    assign ChanStrobe = chan_strobe_q;
    assign FrameDone  = frame_done_q;
    assign Locked     = locked_q;
    assign SyncError  = sync_error_q;

endmodule : tdm_demultiplexer

// File: tb/tb_tdm_demultiplexer.sv
// -----------------------------------------------------------------------------
// tb_tdm_demultiplexer
// Directed bench for tdm_demultiplexer (CHANNELS=4, WIDTH=8, LOCK_FRAMES=2).
// A frame-level reference model predicts every output each cycle; a compare
// process checks it on every falling edge, and the stimulus adds literal
// expectations at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_tdm_demultiplexer;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int LF = 2;

    localparam int M_HUNT    = 0;
    localparam int M_LOCKING = 1;
    localparam int M_LOCKED  = 2;

    logic            Clock = 1'b0;
    logic            Reset_n = 1'b0;
    logic            Enable = 1'b0;
    logic [W-1:0]    SlotIn = '0;
    logic            SlotValid = 1'b0;
    logic            FrameSync = 1'b0;
    logic [CH*W-1:0] ChanOut;
    logic [CH-1:0]   ChanStrobe;
    logic            FrameDone;
    logic            Locked;
    logic            SyncError;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              m_mode;
    int              m_pos;
    int              m_good;
    logic [CH*W-1:0] exp_chan;
    logic [CH-1:0]   exp_strobe;
    logic            exp_done;
    logic            exp_locked;
    logic            exp_err;

    tdm_demultiplexer #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .LOCK_FRAMES (LF)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Enable     (Enable),
        .SlotIn     (SlotIn),
        .SlotValid  (SlotValid),
        .FrameSync  (FrameSync),
        .ChanOut    (ChanOut),
        .ChanStrobe (ChanStrobe),
        .FrameDone  (FrameDone),
        .Locked     (Locked),
        .SyncError  (SyncError)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = M_HUNT;
        m_pos      = 0;
        m_good     = 0;
        exp_chan   = '0;
        exp_strobe = '0;
        exp_done   = 1'b0;
        exp_locked = 1'b0;
        exp_err    = 1'b0;
    endtask

    // One clock edge of the frame-level model.
    task automatic model_step();
        exp_strobe = '0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        if (Enable && SlotValid) begin
            if (m_mode == M_HUNT) begin
                if (FrameSync) begin
                    m_mode = M_LOCKING;
                    m_pos  = 1 % CH;
                    m_good = 0;
                end
            end else if (FrameSync != (m_pos == 0)) begin
                exp_err = 1'b1;
                m_good  = 0;
                if (FrameSync) begin
                    m_mode = M_LOCKING;
                    m_pos  = 1 % CH;
                end else begin
                    m_mode = M_HUNT;
                    m_pos  = 0;
                end
            end else begin
                if (m_mode == M_LOCKED) begin
                    exp_chan[m_pos*W +: W] = SlotIn;
                    exp_strobe[m_pos]      = 1'b1;
                    exp_done               = (m_pos == CH - 1);
                end else if (m_pos == CH - 1) begin
                    m_good = (m_good + 1 > LF) ? LF : m_good + 1;
                    if (m_good == LF) m_mode = M_LOCKED;
                end
                m_pos = (m_pos + 1) % CH;
            end
        end
        exp_locked = (m_mode == M_LOCKED);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clock or negedge Reset_n);
            if (!Reset_n) model_reset();
            else          model_step();
        end
    end

    // Continuous comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge Clock);
            chk("chan_out",   64'(ChanOut),    64'(exp_chan));
            chk("strobe",     64'(ChanStrobe), 64'(exp_strobe));
            chk("frame_done", 64'(FrameDone),  64'(exp_done));
            chk("locked",     64'(Locked),     64'(exp_locked));
            chk("sync_error", 64'(SyncError),  64'(exp_err));
        end
    end

    // Present one slot for one rising edge; returns on the following falling
    // edge, when the outputs reflect that slot.
    task automatic slot(input logic [W-1:0] d, input logic fs);
        Enable    = 1'b1;
        SlotValid = 1'b1;
        SlotIn    = d;
        FrameSync = fs;
        @(negedge Clock);
    endtask

    task automatic slot_noen(input logic [W-1:0] d, input logic fs);
        Enable    = 1'b0;
        SlotValid = 1'b1;
        SlotIn    = d;
        FrameSync = fs;
        @(negedge Clock);
        Enable    = 1'b1;
    endtask

    task automatic idle(input int n);
        SlotValid = 1'b0;
        FrameSync = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    task automatic frame(input logic [W-1:0] base);
        for (int i = 0; i < CH; i++) slot(base + W'(i), (i == 0));
    endtask

    initial begin
        // Reset held for three cycles
        Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_chan",   64'(ChanOut),    64'h0);
        chk("rst_strobe", 64'(ChanStrobe), 64'h0);
        chk("rst_done",   64'(FrameDone),  64'h0);
        chk("rst_locked", 64'(Locked),     64'h0);
        chk("rst_err",    64'(SyncError),  64'h0);
        Reset_n = 1'b1;
        idle(1);

        // Acquire
        frame(8'h10);
        chk("acq_f1_locked", 64'(Locked), 64'h0);
        slot(8'h20, 1'b1); slot(8'h21, 1'b0); slot(8'h22, 1'b0);
        chk("acq_pre_locked", 64'(Locked), 64'h0);
        slot(8'h23, 1'b0);
        chk("acq_locked", 64'(Locked), 64'h1);
        chk("acq_no_write", 64'(ChanOut), 64'h0);
        slot(8'h30, 1'b1);
        chk("f3_strobe0", 64'(ChanStrobe), 64'h1);
        slot(8'h31, 1'b0);
        chk("f3_strobe1", 64'(ChanStrobe), 64'h2);
        slot(8'h32, 1'b0);
        chk("f3_strobe2", 64'(ChanStrobe), 64'h4);
        chk("f3_done2",   64'(FrameDone),  64'h0);
        slot(8'h33, 1'b0);
        chk("f3_strobe3", 64'(ChanStrobe), 64'h8);
        chk("f3_done3",   64'(FrameDone),  64'h1);
        chk("f3_chan",    64'(ChanOut),    64'h33323130);
        idle(2);

        // Early sync on slot 2
        slot(8'h40, 1'b1); slot(8'h41, 1'b0);
        slot(8'h42, 1'b1);
        chk("early_err",    64'(SyncError),  64'h1);
        chk("early_locked", 64'(Locked),     64'h0);
        chk("early_strobe", 64'(ChanStrobe), 64'h0);
        chk("early_chan",   64'(ChanOut),    64'h33324140);
        slot(8'h43, 1'b0); slot(8'h44, 1'b0); slot(8'h45, 1'b0);
        chk("early_relock_wait", 64'(Locked), 64'h0);
        frame(8'h50);
        chk("early_relock", 64'(Locked),  64'h1);
        chk("early_hold",   64'(ChanOut), 64'h33324140);
        frame(8'h60);
        chk("early_write",  64'(ChanOut), 64'h63626160);

        // Missing sync on slot 0
        slot(8'h70, 1'b0);
        chk("miss_err",    64'(SyncError), 64'h1);
        chk("miss_locked", 64'(Locked),    64'h0);
        for (int i = 1; i < CH; i++) begin
            slot(8'h70 + W'(i), 1'b0);
            chk("hunt_no_err",    64'(SyncError),  64'h0);
            chk("hunt_no_strobe", 64'(ChanStrobe), 64'h0);
        end
        frame(8'h80);
        frame(8'h90);
        chk("hunt_relock", 64'(Locked), 64'h1);
        frame(8'hA0);
        chk("hunt_write", 64'(ChanOut), 64'hA3A2A1A0);

        // Gaps and Enable drops inside a frame
        slot(8'hB0, 1'b1);
        idle(3);
        chk("gap_strobe", 64'(ChanStrobe), 64'h0);
        slot(8'hB1, 1'b0);
        chk("gap_strobe1", 64'(ChanStrobe), 64'h2);
        slot_noen(8'hEE, 1'b0);
        slot_noen(8'hEE, 1'b1);
        chk("noen_strobe", 64'(ChanStrobe), 64'h0);
        chk("noen_err",    64'(SyncError),  64'h0);
        slot(8'hB2, 1'b0);
        chk("gap_strobe2", 64'(ChanStrobe), 64'h4);
        idle(3);
        slot(8'hB3, 1'b0);
        chk("gap_done", 64'(FrameDone), 64'h1);
        chk("gap_chan", 64'(ChanOut),   64'hB3B2B1B0);

        // Asynchronous reset mid-frame while locked
        slot(8'hC0, 1'b1); slot(8'hC1, 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_chan",   64'(ChanOut),    64'h0);
        chk("arst_locked", 64'(Locked),     64'h0);
        chk("arst_strobe", 64'(ChanStrobe), 64'h0);
        SlotValid = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        // After reset the block hunts again: unsynced slots do nothing.
        slot(8'hC2, 1'b0);
        chk("post_rst_err", 64'(SyncError), 64'h0);
        frame(8'hD0);
        frame(8'hE0);
        frame(8'hF0);
        chk("post_rst_chan", 64'(ChanOut), 64'hF3F2F1F0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tdm_demultiplexer
